// File: rtl/ext_com_receiver.sv
`timescale 1ns/1ps
// UART receiver for the external-communication path: takes one data frame on rx and answers with a fixed ACK frame on tx.
// Optional macro EXT_RX_SYNC_EN adds a 2-flop synchronizer on rx; otherwise rx passes through a single register stage.
module ext_com_receiver #(
  parameter int                    UART_WIDTH     = 8,
  parameter int                    CLK_FREQ       = 50_000_000,
  parameter int                    UART_BAUD_RATE = 115200,
  parameter logic [UART_WIDTH-1:0] ACK_VALUE      = 8'b11001100
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  enable,
  input  logic                  rx,
  output logic                  tx,
  output logic [UART_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  busy,
  output logic                  frame_error,
  output logic [2:0]            dbg_state
);

  localparam int CLKS_PER_BIT = CLK_FREQ / UART_BAUD_RATE;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W        = (UART_WIDTH > 1) ? $clog2(UART_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(UART_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_ACK_START = 3'd4,
    S_ACK_DATA  = 3'd5,
    S_ACK_STOP  = 3'd6
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_clk_cnt;
  logic [BIT_W-1:0]      r_bit_cnt;
  logic [UART_WIDTH-1:0] r_shift;
  logic                  r_tx;
  logic [UART_WIDTH-1:0] r_data_out;
  logic                  r_data_valid;
  logic                  r_frame_error;
  logic                  w_rx;

`ifdef EXT_RX_SYNC_EN
  logic r_rx_meta;
  logic r_rx_sync;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
    end
  end
`else
  logic r_rx_sync;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) r_rx_sync <= 1'b1;
    else       r_rx_sync <= rx;
  end
`endif

  assign w_rx = r_rx_sync;

  // After a good frame r_shift is reloaded with ACK_VALUE and shifted out LSB first.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state       <= S_IDLE;
      r_clk_cnt     <= '0;
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_tx          <= 1'b1;
      r_data_out    <= '0;
      r_data_valid  <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (enable && !w_rx) begin
            r_state   <= S_START;
            r_clk_cnt <= '0;
          end
        end
        S_START: begin
          if (!enable) begin
            r_state <= S_IDLE;
          end else if (r_clk_cnt == CNT_HALF) begin
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_state   <= w_rx ? S_IDLE : S_DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (!enable) begin
            r_state <= S_IDLE;
          end else if (r_clk_cnt == CNT_LAST) begin
            r_clk_cnt          <= '0;
            r_shift[r_bit_cnt] <= w_rx;
            if (r_bit_cnt == BIT_LAST) begin
              r_bit_cnt <= '0;
              r_state   <= S_STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (!enable) begin
            r_state <= S_IDLE;
          end else if (r_clk_cnt == CNT_LAST) begin
            r_clk_cnt <= '0;
            if (w_rx) begin
              r_data_out    <= r_shift;
              r_data_valid  <= 1'b1;
              r_frame_error <= 1'b0;
              r_shift       <= ACK_VALUE;
              r_state       <= S_ACK_START;
            end else begin
              r_frame_error <= 1'b1;
              r_state       <= S_IDLE;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + CNT_W'(1);
          end
        end
        S_ACK_START: begin
          if (r_clk_cnt == CNT_LAST) begin
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_tx      <= r_shift[0];
            r_shift   <= r_shift >> 1;
            r_state   <= S_ACK_DATA;
          end else begin
            r_tx      <= 1'b0;
            r_clk_cnt <= r_clk_cnt + CNT_W'(1);
          end
        end
        S_ACK_DATA: begin
          if (r_clk_cnt == CNT_LAST) begin
            r_clk_cnt <= '0;
            if (r_bit_cnt == BIT_LAST) begin
              r_bit_cnt <= '0;
              r_tx      <= 1'b1;
              r_state   <= S_ACK_STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + BIT_W'(1);
              r_tx      <= r_shift[0];
              r_shift   <= r_shift >> 1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + CNT_W'(1);
          end
        end
        S_ACK_STOP: begin
          r_tx <= 1'b1;
          if (r_clk_cnt == CNT_LAST) begin
            r_clk_cnt <= '0;
            r_state   <= S_IDLE;
          end else begin
            r_clk_cnt <= r_clk_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_clk_cnt <= '0;
          r_bit_cnt <= '0;
          r_tx      <= 1'b1;
        end
      endcase
    end
  end

  assign tx          = r_tx;
  assign data_out    = r_data_out;
  assign data_valid  = r_data_valid;
  assign frame_error = r_frame_error;
  assign busy        = (r_state != S_IDLE);
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_ext_com_receiver.sv
`timescale 1ns/1ps
// Directed bench for ext_com_receiver: drives UART frames on rx and decodes the ACK frame seen on tx.
module tb_ext_com_receiver;

  localparam int         CPB       = 16;
  localparam logic [9:0] ACK_FRAME = {1'b1, 8'hCC, 1'b0};
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_ACKD   = 3'd5;

  logic       clk = 1'b0;
  logic       rstN;
  logic       enable;
  logic       rx;
  logic       tx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       busy;
  logic       frame_error;
  logic [2:0] dbg_state;

  int total  = 0;
  int bad    = 0;
  int dv_cnt = 0;
  int dv0;
  logic [9:0] mon_q[$];

  ext_com_receiver #(
    .UART_WIDTH     (8),
    .CLK_FREQ       (50_000_000),
    .UART_BAUD_RATE (3_125_000),
    .ACK_VALUE      (8'b11001100)
  ) dut (
    .clk         (clk),
    .rstN        (rstN),
    .enable      (enable),
    .rx          (rx),
    .tx          (tx),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .busy        (busy),
    .frame_error (frame_error),
    .dbg_state   (dbg_state)
  );

  // clock / watchdog
  always #10 clk = ~clk;

  initial begin : watchdog
    #500_000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // data_valid cycles, sampled on the falling edge
  always @(negedge clk) if (data_valid === 1'b1) dv_cnt++;

  // tx frame decoder: {stop, data[7:0], start} per detected falling edge on tx
  initial begin : tx_mon
    logic [9:0] f;
    forever begin
      @(negedge clk);
      if (tx === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        f[0] = tx;
        for (int i = 1; i < 10; i++) begin
          repeat (CPB) @(negedge clk);
          f[i] = tx;
        end
        mon_q.push_back(f);
      end
    end
  end

  // driver / check tasks
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    @(negedge clk);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop_bit);
    rx = 1'b1;
  endtask

  task automatic wait_idle(input int max_cycles);
    for (int i = 0; i < max_cycles && busy !== 1'b0; i++) @(negedge clk);
  endtask

  task automatic check_ack(input string tag);
    check({tag, "_ack_count"}, mon_q.size(), 1);
    if (mon_q.size() > 0) check({tag, "_ack_frame"}, mon_q.pop_front(), ACK_FRAME);
    mon_q.delete();
  endtask

  task automatic check_no_ack(input string tag);
    check({tag, "_no_ack"}, mon_q.size(), 0);
    mon_q.delete();
  endtask

  initial begin : stim
    rstN   = 1'b0;
    enable = 1'b0;
    rx     = 1'b1;
    idle_cycles(3);

    // reset values
    check("rst_tx", tx, 1'b1);
    check("rst_data_out", data_out, 8'h00);
    check("rst_data_valid", data_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_frame_error", frame_error, 1'b0);
    check("rst_state", dbg_state, ST_IDLE);
    rstN = 1'b1;
    idle_cycles(4);
    enable = 1'b1;
    idle_cycles(4);

    // good frame 0x02
    dv0 = dv_cnt;
    send_frame(8'h02, 1'b1);
    wait_idle(12 * CPB);
    check("good_busy_end", busy, 1'b0);
    check("good_data_out", data_out, 8'h02);
    check("good_dv_cycles", dv_cnt - dv0, 1);
    check("good_frame_error", frame_error, 1'b0);
    check("good_tx_idle", tx, 1'b1);
    check_ack("good");

    // glitch rejection: 100 ns low pulse
    dv0 = dv_cnt;
    @(negedge clk);
    rx = 1'b0;
    idle_cycles(3);
    check("glitch_enters_start", dbg_state, ST_START);
    idle_cycles(2);
    rx = 1'b1;
    idle_cycles(2 * CPB);
    check("glitch_busy", busy, 1'b0);
    check("glitch_dv", dv_cnt - dv0, 0);
    check("glitch_tx", tx, 1'b1);
    check("glitch_data_out", data_out, 8'h02);
    check_no_ack("glitch");

    // framing error on 0xA5
    dv0 = dv_cnt;
    send_frame(8'hA5, 1'b0);
    idle_cycles(3 * CPB);
    check("ferr_flag", frame_error, 1'b1);
    check("ferr_data_out", data_out, 8'h02);
    check("ferr_dv", dv_cnt - dv0, 0);
    check("ferr_busy", busy, 1'b0);
    check("ferr_tx", tx, 1'b1);
    check_no_ack("ferr");

    // recovery frame 0x3C clears the sticky error
    dv0 = dv_cnt;
    send_frame(8'h3C, 1'b1);
    wait_idle(12 * CPB);
    check("recov_data_out", data_out, 8'h3C);
    check("recov_frame_error", frame_error, 1'b0);
    check("recov_dv_cycles", dv_cnt - dv0, 1);
    check("recov_busy", busy, 1'b0);
    check_ack("recov");

    // enable low: frame ignored
    dv0 = dv_cnt;
    enable = 1'b0;
    send_frame(8'h55, 1'b1);
    idle_cycles(2 * CPB);
    check("dis_dv", dv_cnt - dv0, 0);
    check("dis_busy", busy, 1'b0);
    check("dis_data_out", data_out, 8'h3C);
    check_no_ack("dis");

    // enable dropped mid-DATA
    enable = 1'b1;
    idle_cycles(4);
    dv0 = dv_cnt;
    @(negedge clk);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    check("abort_in_data", dbg_state, ST_DATA);
    enable = 1'b0;
    @(negedge clk);
    check("abort_busy_1cyc", busy, 1'b0);
    rx = 1'b1;
    idle_cycles(3 * CPB);
    check("abort_dv", dv_cnt - dv0, 0);
    check("abort_data_out", data_out, 8'h3C);
    check("abort_frame_error", frame_error, 1'b0);
    check_no_ack("abort");
    enable = 1'b1;
    idle_cycles(4);

    // enable dropped during ACK_DATA: ACK still completes
    dv0 = dv_cnt;
    send_frame(8'h81, 1'b1);
    for (int i = 0; i < 4 * CPB && dbg_state !== ST_ACKD; i++) @(negedge clk);
    check("ackdrop_in_ack_data", dbg_state, ST_ACKD);
    idle_cycles(CPB);
    enable = 1'b0;
    wait_idle(12 * CPB);
    check("ackdrop_busy", busy, 1'b0);
    check("ackdrop_data_out", data_out, 8'h81);
    check("ackdrop_dv_cycles", dv_cnt - dv0, 1);
    check_ack("ackdrop");
    enable = 1'b1;
    idle_cycles(4);

    // reset asserted mid-DATA of 0xFF
    @(negedge clk);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    check("rstmid_in_data", dbg_state, ST_DATA);
    rstN = 1'b0;
    #1;
    check("rstmid_tx", tx, 1'b1);
    check("rstmid_data_out", data_out, 8'h00);
    check("rstmid_data_valid", data_valid, 1'b0);
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_frame_error", frame_error, 1'b0);
    check("rstmid_state", dbg_state, ST_IDLE);
    rx = 1'b1;
    idle_cycles(3);
    rstN = 1'b1;
    idle_cycles(2 * CPB);
    check_no_ack("rstmid");

    // next good frame 0x11 after reset
    dv0 = dv_cnt;
    send_frame(8'h11, 1'b1);
    wait_idle(12 * CPB);
    check("post_rst_data_out", data_out, 8'h11);
    check("post_rst_dv_cycles", dv_cnt - dv0, 1);
    check("post_rst_frame_error", frame_error, 1'b0);
    check("post_rst_busy", busy, 1'b0);
    check_ack("post_rst");

    // report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
